// File: rtl/decode_stage_pkg.sv
// Shared decode constants, instruction classes and the instruction classifier.
package decode_stage_pkg;

  // Major opcodes
  localparam logic [6:0] OpcOpImm = 7'h13;
  localparam logic [6:0] OpcOp    = 7'h33;
  localparam logic [6:0] OpcLui   = 7'h37;

  // funct3 values
  localparam logic [2:0] F3AddSub = 3'h0;
  localparam logic [2:0] F3Slt    = 3'h2;
  localparam logic [2:0] F3Sltu   = 3'h3;
  localparam logic [2:0] F3Mul    = 3'h0;
  localparam logic [2:0] F3Div    = 3'h4;
  localparam logic [2:0] F3Divu   = 3'h5;
  localparam logic [2:0] F3Rem    = 3'h6;
  localparam logic [2:0] F3Remu   = 3'h7;

  // funct7 values
  localparam logic [6:0] F7Base   = 7'h00;
  localparam logic [6:0] F7Alt    = 7'h20;
  localparam logic [6:0] F7MulDiv = 7'h01;

  // resultSelect codes
  localparam int unsigned ResAdd = 0;
  localparam int unsigned ResMul = 1;
  localparam int unsigned ResDiv = 2;
  localparam int unsigned ResRem = 3;
  localparam int unsigned ResCmp = 6;

  typedef enum logic [3:0] {
    InsNone,
    InsAddi,
    InsSlti,
    InsSltiu,
    InsAdd,
    InsSub,
    InsSlt,
    InsSltu,
    InsMul,
    InsDiv,
    InsDivu,
    InsRem,
    InsRemu,
    InsLui
  } ins_kind_e;

  // Map a raw instruction onto one of the supported classes (InsNone if unsupported).
  function automatic ins_kind_e classify(logic [31:0] instr);
    ins_kind_e  kind;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc  = instr[6:0];
    f3   = instr[14:12];
    f7   = instr[31:25];
    kind = InsNone;
    case (opc)
      OpcOpImm: begin
        case (f3)
          F3AddSub: kind = InsAddi;
          F3Slt:    kind = InsSlti;
          F3Sltu:   kind = InsSltiu;
          default:  kind = InsNone;
        endcase
      end
      OpcOp: begin
        case (f7)
          F7Base: begin
            case (f3)
              F3AddSub: kind = InsAdd;
              F3Slt:    kind = InsSlt;
              F3Sltu:   kind = InsSltu;
              default:  kind = InsNone;
            endcase
          end
          F7Alt: begin
            if (f3 == F3AddSub) kind = InsSub;
          end
          F7MulDiv: begin
            case (f3)
              F3Mul:   kind = InsMul;
              F3Div:   kind = InsDiv;
              F3Divu:  kind = InsDivu;
              F3Rem:   kind = InsRem;
              F3Remu:  kind = InsRemu;
              default: kind = InsNone;
            endcase
          end
          default: kind = InsNone;
        endcase
      end
      OpcLui:  kind = InsLui;
      default: kind = InsNone;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/decode_stage_reg_scoreboard.sv
// Busy-bit scoreboard for registers owned by in-flight multi-cycle ops.
// Two source read ports plus a destination check port; x0 is never busy.
module decode_stage_reg_scoreboard #(
  parameter int unsigned AddrBits = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_en_i,
  input  logic [AddrBits-1:0] set_addr_i,
  input  logic                clr_en_i,
  input  logic [AddrBits-1:0] clr_addr_i,
  input  logic [AddrBits-1:0] rd_a_addr_i,
  input  logic [AddrBits-1:0] rd_b_addr_i,
  input  logic [AddrBits-1:0] rd_c_addr_i,
  output logic                busy_a_o,
  output logic                busy_b_o,
  output logic                busy_c_o
);

  localparam int unsigned Entries = 2 ** AddrBits;

  logic [Entries-1:0] busy_q, busy_d;

  // Next busy vector: clear first so a same-address set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a_o = busy_q[rd_a_addr_i];
  assign busy_b_o = busy_q[rd_b_addr_i];
  assign busy_c_o = busy_q[rd_c_addr_i];

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/M ALU decode stage with valid/ready handshake and a
// scoreboard that stalls instructions depending on in-flight MUL/DIV/REM results.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned REGADDR_BITS    = 5,
  parameter int unsigned RESULT_SEL_BITS = 3,
  parameter int unsigned MUL_MULTICYCLE  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [31:0]                instructionIn,
  input  logic                       flush,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [REGADDR_BITS-1:0]    a_location,
  output logic [REGADDR_BITS-1:0]    b_location,
  output logic                       immediateSelect,
  output logic [DATA_WIDTH-1:0]      immediateVal,
  output logic                       unsignedSelect,
  output logic                       subtractEnable,
  output logic [REGADDR_BITS-1:0]    writeSelect,
  output logic                       writeEnable,
  output logic [RESULT_SEL_BITS-1:0] resultSelect,
  output logic                       error,
  input  logic                       wbDoneValid,
  input  logic [REGADDR_BITS-1:0]    wbDoneAddr
);

  // Raw instruction fields
  ins_kind_e                ins_kind;
  logic [REGADDR_BITS-1:0]  rd, rs1, rs2;
  logic [DATA_WIDTH-1:0]    imm_i, imm_u;

  assign ins_kind = classify(instructionIn);
  assign rd       = REGADDR_BITS'(instructionIn[11:7]);
  assign rs1      = REGADDR_BITS'(instructionIn[19:15]);
  assign rs2      = REGADDR_BITS'(instructionIn[24:20]);
  assign imm_i    = DATA_WIDTH'($signed(instructionIn[31:20]));
  assign imm_u    = DATA_WIDTH'($signed({instructionIn[31:12], 12'h000}));

  // Decoded fields for the incoming instruction
  logic                       dec_sup, dec_we, dec_mc, dec_err;
  logic                       dec_use_rs1, dec_use_rs2;
  logic [REGADDR_BITS-1:0]    dec_a, dec_b, dec_ws;
  logic                       dec_imm_sel, dec_uns, dec_sub;
  logic [DATA_WIDTH-1:0]      dec_imm;
  logic [RESULT_SEL_BITS-1:0] dec_res;

  assign dec_sup = (ins_kind != InsNone);
  assign dec_we  = dec_sup && (rd != '0);
  assign dec_ws  = dec_sup ? rd : '0;

  // Field decode per instruction class; unsupported encodings only raise error.
  always_comb begin
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_a       = '0;
    dec_b       = '0;
    dec_imm_sel = 1'b0;
    dec_imm     = '0;
    dec_uns     = 1'b0;
    dec_sub     = 1'b0;
    dec_res     = RESULT_SEL_BITS'(ResAdd);
    dec_mc      = 1'b0;
    dec_err     = 1'b0;
    unique case (ins_kind)
      InsAddi, InsSlti, InsSltiu: begin
        dec_use_rs1 = 1'b1;
        dec_a       = rs1;
        dec_imm_sel = 1'b1;
        dec_imm     = imm_i;
        dec_uns     = (ins_kind == InsSltiu);
        dec_res     = (ins_kind == InsAddi) ? RESULT_SEL_BITS'(ResAdd)
                                            : RESULT_SEL_BITS'(ResCmp);
      end
      InsAdd, InsSub, InsSlt, InsSltu: begin
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_a       = rs1;
        dec_b       = rs2;
        dec_sub     = (ins_kind == InsSub);
        dec_uns     = (ins_kind == InsSltu);
        dec_res     = (ins_kind == InsSlt || ins_kind == InsSltu) ? RESULT_SEL_BITS'(ResCmp)
                                                                  : RESULT_SEL_BITS'(ResAdd);
      end
      InsMul: begin
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_a       = rs1;
        dec_b       = rs2;
        dec_res     = RESULT_SEL_BITS'(ResMul);
        dec_mc      = (MUL_MULTICYCLE != 0);
      end
      InsDiv, InsDivu: begin
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_a       = rs1;
        dec_b       = rs2;
        dec_uns     = (ins_kind == InsDivu);
        dec_res     = RESULT_SEL_BITS'(ResDiv);
        dec_mc      = 1'b1;
      end
      InsRem, InsRemu: begin
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_a       = rs1;
        dec_b       = rs2;
        dec_uns     = (ins_kind == InsRemu);
        dec_res     = RESULT_SEL_BITS'(ResRem);
        dec_mc      = 1'b1;
      end
      InsLui: begin
        dec_imm_sel = 1'b1;
        dec_imm     = imm_u;
      end
      default: begin
        dec_err = 1'b1;
      end
    endcase
  end

  // Output pipeline register state
  logic                       out_valid_q, out_valid_d;
  logic                       mc_q;
  logic [REGADDR_BITS-1:0]    a_q, b_q, ws_q;
  logic                       imm_sel_q, uns_q, sub_q, we_q, err_q;
  logic [DATA_WIDTH-1:0]      imm_q;
  logic [RESULT_SEL_BITS-1:0] res_q;

  // Scoreboard hookup
  logic sb_busy_a, sb_busy_b, sb_busy_c, sb_set;
  logic out_fire, in_fire, load;

  assign out_fire = out_valid_q && outReady;
  // A flushed instruction must not claim its destination.
  assign sb_set   = out_fire && mc_q && we_q && !flush;

  decode_stage_reg_scoreboard #(
    .AddrBits (REGADDR_BITS)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_i       (reset),
    .set_en_i    (sb_set),
    .set_addr_i  (ws_q),
    .clr_en_i    (wbDoneValid),
    .clr_addr_i  (wbDoneAddr),
    .rd_a_addr_i (rs1),
    .rd_b_addr_i (rs2),
    .rd_c_addr_i (rd),
    .busy_a_o    (sb_busy_a),
    .busy_b_o    (sb_busy_b),
    .busy_c_o    (sb_busy_c)
  );

  // Hazard: registered busy bits, plus the held MC op that has not yet set its bit.
  logic hz_sb, hz_held, hold_claims, hazard;

  assign hold_claims = out_valid_q && mc_q && we_q;
  assign hz_sb   = (dec_use_rs1 && sb_busy_a) || (dec_use_rs2 && sb_busy_b) ||
                   (dec_we && sb_busy_c);
  assign hz_held = hold_claims && ((dec_use_rs1 && ws_q == rs1) ||
                                   (dec_use_rs2 && ws_q == rs2) ||
                                   (dec_we && ws_q == rd));
  assign hazard  = inValid && dec_sup && (hz_sb || hz_held);

  assign inReady = (!out_valid_q || outReady) && !hazard;
  assign in_fire = inValid && inReady;
  assign load    = in_fire && !flush;

  // Output valid next state: flush beats accept, accept beats drain.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_valid_d = 1'b1;
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end
  end

  // Output pipeline register; fields load only on an unflushed accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      mc_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ws_q        <= '0;
      imm_sel_q   <= 1'b0;
      uns_q       <= 1'b0;
      sub_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      imm_q       <= '0;
      res_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        mc_q      <= dec_mc;
        a_q       <= dec_a;
        b_q       <= dec_b;
        ws_q      <= dec_ws;
        imm_sel_q <= dec_imm_sel;
        uns_q     <= dec_uns;
        sub_q     <= dec_sub;
        we_q      <= dec_we;
        err_q     <= dec_err;
        imm_q     <= dec_imm;
        res_q     <= dec_res;
      end
    end
  end

  assign outValid        = out_valid_q;
  assign a_location      = a_q;
  assign b_location      = b_q;
  assign immediateSelect = imm_sel_q;
  assign immediateVal    = imm_q;
  assign unsignedSelect  = uns_q;
  assign subtractEnable  = sub_q;
  assign writeSelect     = ws_q;
  assign writeEnable     = we_q;
  assign resultSelect    = res_q;
  assign error           = err_q;

endmodule
